// File: rtl/qe_pkg.sv
// Shared constants for the QE datapath and its result collector.
// Also holds the saturating increment used by the collector's drop counter.
package qe_pkg;

  localparam int QE_OPERAND_W = 8;
  localparam int QE_RESULT_W  = 16;
  localparam int QE_SEQ_W     = 8;
  localparam int QE_DROP_W    = 8;

  function automatic logic [QE_DROP_W-1:0] sat_inc_drop(input logic [QE_DROP_W-1:0] v);
    if (v == {QE_DROP_W{1'b1}}) begin
      sat_inc_drop = v;
    end else begin
      sat_inc_drop = v + QE_DROP_W'(1'b1);
    end
  endfunction

endpackage

// File: rtl/qe_rc_mem.sv
// Register-array storage for the result collector.
// One synchronous write port, one asynchronous read port; contents are never reset.
module qe_rc_mem #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] mem_r [DEPTH];

  // storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/qe_result_collector.sv
// FWFT result buffer behind QE_M: never stalls the producer, drops and counts on overflow.
// Optional feature macro QE_RC_SEQ_EN adds an 8-bit per-word sequence tag on out_seq.
module qe_result_collector
  import qe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = QE_RESULT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           result_in,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [QE_DROP_W-1:0]       drop_cnt
`ifdef QE_RC_SEQ_EN
  ,
  output logic [QE_SEQ_W-1:0]        out_seq
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef QE_RC_SEQ_EN
  localparam int MEM_W = WIDTH + QE_SEQ_W;
`else
  localparam int MEM_W = WIDTH;
`endif
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 full_r, empty_r, valid_r, overflow_r;
  logic [QE_DROP_W-1:0] drop_cnt_r;
  logic [WIDTH-1:0]     data_r;

  logic                 push_s, pop_s, drop_s;
  logic [PTR_W-1:0]     wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CNT_W-1:0]     count_nxt_s;
  logic                 overflow_nxt_s;
  logic [QE_DROP_W-1:0] drop_cnt_nxt_s;
  logic [MEM_W-1:0]     wr_word_s, rd_word_s, head_s;

`ifdef QE_RC_SEQ_EN
  logic [QE_SEQ_W-1:0]  seq_cnt_r, seq_r;
  assign wr_word_s = {seq_cnt_r, result_in};
`else
  assign wr_word_s = result_in;
`endif

  // A full FIFO still accepts a word when the consumer frees a slot on the same edge.
  assign pop_s  = valid_r & out_ready;
  assign push_s = valid_in & (~full_r | pop_s);
  assign drop_s = valid_in & full_r & ~pop_s;

  qe_rc_mem #(
    .DEPTH (DEPTH),
    .DW    (MEM_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_word_s),
    .rd_addr (rd_ptr_nxt_s),
    .rd_data (rd_word_s)
  );

  // next pointers, occupancy and the word that will sit at the head after this edge
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    head_s       = rd_word_s;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    // the head slot is being written this edge only when the FIFO would otherwise be empty
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_s = wr_word_s;
    end else begin
      head_s = rd_word_s;
    end
  end

  // overflow flag and drop counter; a drop outranks a simultaneous clear
  always_comb begin
    overflow_nxt_s = overflow_r;
    drop_cnt_nxt_s = drop_cnt_r;
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
      if (clear) begin
        drop_cnt_nxt_s = QE_DROP_W'(1'b1);
      end else begin
        drop_cnt_nxt_s = sat_inc_drop(drop_cnt_r);
      end
    end else if (clear) begin
      overflow_nxt_s = 1'b0;
      drop_cnt_nxt_s = '0;
    end else begin
      overflow_nxt_s = overflow_r;
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
      data_r     <= '0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == CNT_FULL);
      empty_r    <= (count_nxt_s == '0);
      valid_r    <= (count_nxt_s != '0);
      overflow_r <= overflow_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
      if (count_nxt_s != '0) begin
        data_r <= head_s[WIDTH-1:0];
      end else begin
        data_r <= data_r;
      end
    end
  end

`ifdef QE_RC_SEQ_EN
  // sequence tag counter and the tag of the presented word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_cnt_r <= '0;
      seq_r     <= '0;
    end else begin
      if (push_s) begin
        seq_cnt_r <= seq_cnt_r + QE_SEQ_W'(1'b1);
      end else begin
        seq_cnt_r <= seq_cnt_r;
      end
      if (count_nxt_s != '0) begin
        seq_r <= head_s[MEM_W-1:WIDTH];
      end else begin
        seq_r <= seq_r;
      end
    end
  end
  assign out_seq = seq_r;
`endif

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign overflow  = overflow_r;
  assign drop_cnt  = drop_cnt_r;

endmodule
